accel_incr_core: RTL and testbench
==================================

// Module: accel_incr_core
// PURPOSE
//  Memory-mapped responder behind the accelerator wrapper's internal memory port (req/addr/we/be/wdata/rdata).
//  Holds the control/status registers and a DEPTH-word data memory.
//  Runs an increment engine: data[i] += INCREMENT for i in 0..MAX_CNT-1, then raises done_o.
//  Acts as the slave end of the port driven by the AXI-to-mem bridge and the wrapper benches.
// PARAMETERS
//  INT_ADDR_WIDTH  20   internal address width; MSB=1 selects data memory, MSB=0 selects register space
//  DATA_WIDTH      32   bus/data word width
//  MEM_DEPTH       256  data memory words
//  CTRL_WORDS      1    control words, at reg addr 0..CTRL_WORDS-1
//  STAT_WORDS      3    status words, at reg addr CTRL_WORDS..CTRL_WORDS+STAT_WORDS-1
// PORTS
//  clk_s        in   1               clock
//  rst_n_s      in   1               asynchronous reset, active-low
//  testmode_i   in   1               scan/test mode; no functional effect
//  mem_req_i    in   1               access request, one access per cycle, never back-pressured
//  mem_addr_i   in   INT_ADDR_WIDTH  word address
//  mem_we_i     in   1               1=write, 0=read
//  mem_be_i     in   DATA_WIDTH/8    byte enables (writes only)
//  mem_wdata_i  in   DATA_WIDTH      write data
//  mem_rdata_o  out  DATA_WIDTH      read data, valid the cycle after a read request
//  done_o       out  1               engine finished; level signal
// BEHAVIOUR
//  Reset: mem_rdata_o=0, done_o=0, CTRL=0, status=0, FSM=IDLE. Data memory is not reset.
//  Read: latency 1 cycle. mem_rdata_o holds its last value when no read is pending.
//  Unmapped register address reads 0. Data address >= MEM_DEPTH reads 0; writes there are dropped.
//  Write: byte-enabled into CTRL and data memory. Writes to status words are ignored.
//  CTRL layout: [0]=start, [15:8]=max_cnt, [23:16]=increment.
//  Status words:
//   - STAT0 = {30'b0, busy, done}
//   - STAT1 = words processed
//   - STAT2 = busy-cycle count
//  Start: a write with be[0]=1 and wdata[0]=1 while IDLE or DONE is accepted.
//   - Engine latches max_cnt/increment, clears done_o, STAT1 and STAT2; CTRL[0] self-clears next cycle.
//   - A start write while busy updates CTRL[23:8] only; start is ignored and CTRL[0] stays 0.
//  FSM: IDLE -> RD -> WR -> (RD | DONE); DONE -> RD on the next start.
//   - RD: engine reads data[i].
//   - WR: writes data[i] + increment (increment zero-extended), i++, STAT1++.
//   - Last WR (i == N-1) -> DONE. DONE holds done_o=1 until the next accepted start or reset.
//  Timing: start captured at edge E0; done_o high from edge E0+2N+S (S = stall cycles).
//  N = min(max_cnt, MEM_DEPTH). N=0: FSM goes straight to DONE, so done_o is high from E0+1.
//  Arbitration: a bus data-memory access in the same cycle as an engine RD/WR wins; the engine holds state one cycle (stall).
//   - Register accesses never stall the engine.
//  STAT2 increments every cycle with busy=1, including stalls; saturates at all-ones.
//  Arithmetic: DATA_WIDTH wide, wraps modulo 2^DATA_WIDTH (see CONFIGURATION).
//  Reset mid-operation: FSM aborts to IDLE; words already written keep their new values.
// CONFIGURATION
//  ACCEL_INCR_SATURATE_EN:
//   - defined: the adder saturates at 2^DATA_WIDTH-1.
//   - undefined: the adder wraps.
//   - No other behaviour differs.
// TESTING
//  1. Reset, read CTRL/STAT0..2 -> all 0; done_o=0.
//  2. Write data[k]=4k..4k+3 byte pattern (k=0..63), write CTRL=0x00014001 -> done_o rises 128 cycles after the start edge.
//     Each data[k] equals its written value +1; STAT1=64, STAT2=128, STAT0=1.
//  3. max_cnt=0 start -> done_o high next cycle; memory unchanged; STAT1=0.
//  4. data[0]=0xFFFFFFFF, inc=2, max_cnt=1 -> data[0]=0x00000001 (saturate build: 0xFFFFFFFF).
//  5. Bus reads data[5] every cycle during a 64-word run -> each read stalls one engine cycle; STAT2 = 128 + reads; results correct.
//  6. Start while busy with max_cnt=8 -> ignored, run completes with the original N.
//     Assert rst_n_s mid-run -> IDLE, done_o=0; partially updated words persist.

Source files
------------

// File: rtl/accel_incr_core_if.sv
// Internal memory port between the AXI-to-mem bridge (master) and the
// accelerator core (slave). Word addressed; address MSB selects data memory.
interface accel_incr_core_if #(
  parameter int INT_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 32
);
  // Handshake: the master raises mem_req_i for one cycle per access and the
  // slave always accepts it (there is no ready). For a read (mem_we_i=0),
  // mem_rdata_o is valid the cycle after the request and then holds until the
  // next read completes. mem_be_i only qualifies writes.
  logic                      mem_req_i;
  logic [INT_ADDR_WIDTH-1:0] mem_addr_i;
  logic                      mem_we_i;
  logic [DATA_WIDTH/8-1:0]   mem_be_i;
  logic [DATA_WIDTH-1:0]     mem_wdata_i;
  logic [DATA_WIDTH-1:0]     mem_rdata_o;

  modport master (
    output mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    input  mem_rdata_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, mem_we_i, mem_be_i, mem_wdata_i,
    output mem_rdata_o
  );
endinterface

// File: rtl/accel_incr_core.sv
// accel_incr_core: memory-mapped control/status registers, a MEM_DEPTH-word
// data memory and an increment engine (data[i] += increment, i < N).
// Optional build macro ACCEL_INCR_SATURATE_EN: the engine adder saturates at
// all-ones instead of wrapping.
module accel_incr_core #(
  parameter int INT_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int CTRL_WORDS     = 1,
  parameter int STAT_WORDS     = 3
) (
  input  logic                    clk_s,
  input  logic                    rst_n_s,
  input  logic                    testmode_i,
  accel_incr_core_if.slave        mem,
  output logic                    done_o,
  output logic [1:0]              dbg_state_o
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = INT_ADDR_WIDTH - 1;
  localparam int MA_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = $clog2(MEM_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] ctrl_q [CTRL_WORDS];
  logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] stat1_q;
  logic [DATA_WIDTH-1:0] stat2_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] eng_rd_q;
  logic [DATA_WIDTH-1:0] sum;
  logic [CNT_W-1:0]      i_q;
  logic [CNT_W-1:0]      n_q;
  logic [CNT_W-1:0]      new_n;
  logic [7:0]            inc_q;

  logic                  is_data;
  logic [OFF_W-1:0]      offs;
  logic [31:0]           offs32;
  logic [31:0]           stat_sel;
  logic                  data_in_range;
  logic [MA_W-1:0]       data_idx;
  logic [MA_W-1:0]       eng_idx;
  logic                  bus_data_acc;
  logic                  bus_wr_data;
  logic                  bus_rd;
  logic                  wr_ctrl0;
  logic                  start_req;
  logic                  busy;
  logic                  start_acc;
  logic                  stall;
  logic                  eng_rd;
  logic                  eng_wr;
  logic [DATA_WIDTH-1:0] ctrl0_merged;
  logic [DATA_WIDTH-1:0] ctrl0_next;
  logic [DATA_WIDTH-1:0] rd_mux;

  // Scan/test mode has no functional effect on this block.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_W-1:0]       be
  );
    byte_merge = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) byte_merge[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  // Address decode, arbitration and start qualification.
  always_comb begin
    is_data       = mem.mem_addr_i[INT_ADDR_WIDTH-1];
    offs          = mem.mem_addr_i[OFF_W-1:0];
    offs32        = 32'(offs);
    stat_sel      = offs32 - 32'(CTRL_WORDS);
    data_in_range = offs32 < 32'(MEM_DEPTH);
    data_idx      = offs[MA_W-1:0];
    eng_idx       = i_q[MA_W-1:0];
    bus_data_acc  = mem.mem_req_i && is_data;
    bus_wr_data   = bus_data_acc && mem.mem_we_i && data_in_range;
    bus_rd        = mem.mem_req_i && !mem.mem_we_i;
    wr_ctrl0      = mem.mem_req_i && mem.mem_we_i && !is_data && (offs32 == 32'd0);
    start_req     = wr_ctrl0 && mem.mem_be_i[0] && mem.mem_wdata_i[0];
    busy          = (state_q == S_RD) || (state_q == S_WR);
    start_acc     = start_req && !busy;
    // Any bus data-memory access owns the memory this cycle; the engine waits.
    stall         = bus_data_acc;
    eng_rd        = (state_q == S_RD) && !stall && (n_q != '0);
    eng_wr        = (state_q == S_WR) && !stall;
  end

  // Next CTRL word: only the parameter fields are writable while running;
  // the start bit is set only by an accepted start and clears one cycle later.
  always_comb begin
    ctrl0_merged = byte_merge(ctrl_q[0], mem.mem_wdata_i, mem.mem_be_i);
    ctrl0_next   = ctrl_q[0];
    if (wr_ctrl0) begin
      if (busy) ctrl0_next[23:8] = ctrl0_merged[23:8];
      else      ctrl0_next       = ctrl0_merged;
    end
    ctrl0_next[0] = start_acc;
    if (32'(ctrl0_merged[15:8]) > 32'(MEM_DEPTH)) new_n = CNT_W'(MEM_DEPTH);
    else                                          new_n = CNT_W'(ctrl0_merged[15:8]);
  end

`ifdef ACCEL_INCR_SATURATE_EN
  logic [DATA_WIDTH:0] wide_sum;
  // Saturating adder: clamp to all-ones on carry out.
  always_comb begin
    wide_sum = {1'b0, eng_rd_q} + (DATA_WIDTH+1)'(inc_q);
    sum      = wide_sum[DATA_WIDTH] ? '1 : wide_sum[DATA_WIDTH-1:0];
  end
`else
  // Wrapping adder, modulo 2^DATA_WIDTH.
  always_comb begin
    sum = eng_rd_q + DATA_WIDTH'(inc_q);
  end
`endif

  // Read mux: data memory, control words, status words, otherwise zero.
  always_comb begin
    rd_mux = '0;
    if (is_data) begin
      if (data_in_range) rd_mux = mem_q[data_idx];
    end else if (offs32 < 32'(CTRL_WORDS)) begin
      for (int k = 0; k < CTRL_WORDS; k++) begin
        if (offs32 == 32'(k)) rd_mux = ctrl_q[k];
      end
    end else if (stat_sel < 32'(STAT_WORDS)) begin
      case (stat_sel)
        32'd0:   rd_mux = {{(DATA_WIDTH-2){1'b0}}, busy, done_o};
        32'd1:   rd_mux = stat1_q;
        32'd2:   rd_mux = stat2_q;
        default: rd_mux = '0;
      endcase
    end
  end

  // Control registers and registered read data.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int k = 0; k < CTRL_WORDS; k++) ctrl_q[k] <= '0;
      rdata_q <= '0;
    end else begin
      ctrl_q[0] <= ctrl0_next;
      for (int k = 1; k < CTRL_WORDS; k++) begin
        if (mem.mem_req_i && mem.mem_we_i && !is_data && (offs32 == 32'(k)))
          ctrl_q[k] <= byte_merge(ctrl_q[k], mem.mem_wdata_i, mem.mem_be_i);
      end
      if (bus_rd) rdata_q <= rd_mux;
    end
  end

  // Data memory (not reset): bus byte writes, engine word writes and reads.
  always_ff @(posedge clk_s) begin
    if (bus_wr_data) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem.mem_be_i[b]) mem_q[data_idx][8*b +: 8] <= mem.mem_wdata_i[8*b +: 8];
      end
    end else if (eng_wr) begin
      mem_q[eng_idx] <= sum;
    end
    if (eng_rd) eng_rd_q <= mem_q[eng_idx];
  end

  // Engine FSM with done flag and status counters.
  always_ff @(posedge clk_s or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      n_q     <= '0;
      inc_q   <= '0;
      done_o  <= 1'b0;
      stat1_q <= '0;
      stat2_q <= '0;
    end else begin
      if (busy && (stat2_q != '1)) stat2_q <= stat2_q + DATA_WIDTH'(1);
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_acc) begin
            n_q     <= new_n;
            inc_q   <= ctrl0_merged[23:16];
            i_q     <= '0;
            stat1_q <= '0;
            stat2_q <= '0;
            done_o  <= 1'b0;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          if (n_q == '0) begin
            done_o  <= 1'b1;
            state_q <= S_DONE;
          end else if (!stall) begin
            state_q <= S_WR;
          end
        end
        S_WR: begin
          if (!stall) begin
            i_q     <= i_q + CNT_W'(1);
            stat1_q <= stat1_q + DATA_WIDTH'(1);
            if (i_q == n_q - CNT_W'(1)) begin
              done_o  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.mem_rdata_o = rdata_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_accel_incr_core.sv
// Bench for accel_incr_core: bus driver tasks, a behavioural memory model and
// one task per scenario with inline comparisons.
module tb_accel_incr_core;
  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam logic [AW-1:0] DATA_BASE = 20'h80000;

  logic          clk_s = 1'b0;
  logic          rst_n_s = 1'b0;
  logic          testmode_i = 1'b0;
  logic          done_o;
  logic [1:0]    dbg_state;

  accel_incr_core_if #(.INT_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  accel_incr_core #(
    .INT_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .CTRL_WORDS(1), .STAT_WORDS(3)
  ) dut (
    .clk_s       (clk_s),
    .rst_n_s     (rst_n_s),
    .testmode_i  (testmode_i),
    .mem         (bus),
    .done_o      (done_o),
    .dbg_state_o (dbg_state)
  );

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] act_q [$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_s = ~clk_s;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    @(posedge clk_s);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clk_s);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1;
    bus.mem_addr_i = a; bus.mem_wdata_i = d; bus.mem_be_i = be;
    @(posedge clk_s);
    #1;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk_s);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = a;
    @(posedge clk_s);
    #1;
    bus.mem_req_i = 1'b0;
    d = bus.mem_rdata_o;
  endtask

  task automatic dump_mem(input int hi);
    logic [DW-1:0] d;
    act_q.delete();
    for (int k = 0; k <= hi; k++) begin
      bus_read(DATA_BASE + AW'(k), d);
      act_q.push_back(d);
    end
  endtask

  // Counts edges since the start edge until done_o is seen, bounded.
  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (done_o !== 1'b1 && cyc < 3000) begin
      idle_cycle();
      cyc++;
    end
  endtask

  task automatic init_mem();
    logic [DW-1:0] d;
    for (int k = 0; k < DEPTH; k++) begin
      d = $urandom;
      bus_write(DATA_BASE + AW'(k), d, 4'hF);
      model_mem[k] = d;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [7:0] inc);
    logic [63:0] s;
    s = {32'b0, a} + {56'b0, inc};
`ifdef ACCEL_INCR_SATURATE_EN
    if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return s[31:0];
  endfunction

  task automatic ref_run(input int max_cnt, input logic [7:0] inc, input int limit, output int n);
    n = (max_cnt < DEPTH) ? max_cnt : DEPTH;
    for (int i = 0; i < n && i < limit; i++) model_mem[i] = ref_add(model_mem[i], inc);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [DW-1:0] d;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done_o); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    checks++; if (bus.mem_rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", bus.mem_rdata_o); end
    for (int r = 0; r < 4; r++) begin
      bus_read(AW'(r), d);
      checks++;
      if (d !== '0) begin errors++; $display("FAIL reset_reg[%0d]: got %h exp 0", r, d); end
    end
  endtask

  task automatic test_map();
    logic [DW-1:0] d, w, e;
    logic [3:0] be;
    bus_read(20'h00010, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL map_unmapped: got %h exp 0", d); end
    bus_read(20'h00004, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL map_past_stat: got %h exp 0", d); end
    bus_write(20'h00002, 32'hFFFF_FFFF, 4'hF);
    bus_read(20'h00002, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL map_stat_ro: got %h exp 0", d); end
    bus_write(DATA_BASE + 20'd300, 32'h1234_5678, 4'hF);
    bus_read(DATA_BASE + 20'd300, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL map_oor_read: got %h exp 0", d); end
    bus_read(DATA_BASE + 20'd44, d);
    checks++; if (d !== model_mem[44]) begin errors++; $display("FAIL map_oor_alias: got %h exp %h", d, model_mem[44]); end
    w = $urandom;
    be = 4'b0101;
    bus_write(DATA_BASE + 20'd10, w, be);
    e = model_mem[10];
    for (int b = 0; b < 4; b++) if (be[b]) e[8*b +: 8] = w[8*b +: 8];
    model_mem[10] = e;
    bus_read(DATA_BASE + 20'd10, d);
    checks++; if (d !== e) begin errors++; $display("FAIL map_byte_en: got %h exp %h", d, e); end
    bus_write(20'h00000, 32'hAAFF_77FF, 4'b0110);
    bus_read(20'h00000, d);
    checks++; if (d !== 32'h00FF_7700) begin errors++; $display("FAIL map_ctrl_be: got %h exp 00ff7700", d); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL map_no_start: got %b exp 0", done_o); end
  endtask

  task automatic test_increment();
    logic [DW-1:0] d, e, a;
    int cyc, n;
    for (int k = 0; k < 64; k++) begin
      d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      bus_write(DATA_BASE + AW'(k), d, 4'hF);
      model_mem[k] = d;
    end
    bus_write(20'h00000, 32'h0001_4001, 4'hF);
    ref_run(64, 8'd1, DEPTH, n);
    wait_done(0, cyc);
    checks++; if (cyc !== 128) begin errors++; $display("FAIL incr_done_time: got %0d exp 128", cyc); end
    bus_read(20'h00002, d);
    checks++; if (d !== 32'd64) begin errors++; $display("FAIL incr_stat1: got %0d exp 64", d); end
    bus_read(20'h00003, d);
    checks++; if (d !== 32'd128) begin errors++; $display("FAIL incr_stat2: got %0d exp 128", d); end
    bus_read(20'h00001, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL incr_stat0: got %h exp 1", d); end
    dump_mem(71);
    for (int k = 0; k <= 71; k++) exp_q.push_back(model_mem[k]);
    for (int k = 0; k <= 71; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL incr_mem[%0d]: got %h exp %h", k, a, e); end
    end
  endtask

  task automatic test_zero_cnt();
    logic [DW-1:0] d, e, a;
    int cyc;
    bus_write(20'h00000, 32'h0005_0001, 4'hF);
    wait_done(0, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL zero_done_time: got %0d exp 1", cyc); end
    bus_read(20'h00002, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL zero_stat1: got %0d exp 0", d); end
    dump_mem(7);
    for (int k = 0; k <= 7; k++) exp_q.push_back(model_mem[k]);
    for (int k = 0; k <= 7; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL zero_mem[%0d]: got %h exp %h", k, a, e); end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d, e;
    int cyc, n;
    bus_write(DATA_BASE, 32'hFFFF_FFFF, 4'hF);
    model_mem[0] = 32'hFFFF_FFFF;
    bus_write(20'h00000, 32'h0002_0101, 4'hF);
    ref_run(1, 8'd2, DEPTH, n);
    wait_done(0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL wrap_done_time: got %0d exp 2", cyc); end
`ifdef ACCEL_INCR_SATURATE_EN
    e = 32'hFFFF_FFFF;
`else
    e = 32'h0000_0001;
`endif
    bus_read(DATA_BASE, d);
    checks++; if (d !== e) begin errors++; $display("FAIL wrap_data0: got %h exp %h", d, e); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] d, e, a;
    int cyc, n, reads;
    reads = 0;
    cyc = 0;
    bus_write(20'h00000, 32'h0003_4001, 4'hF);
    ref_run(64, 8'd3, DEPTH, n);
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus_read(DATA_BASE + 20'd5, d);
        reads++;
      end else begin
        idle_cycle();
      end
      cyc++;
    end
    wait_done(cyc, cyc);
    checks++; if (cyc !== 128 + reads) begin errors++; $display("FAIL stall_done_time: got %0d exp %0d", cyc, 128 + reads); end
    bus_read(20'h00003, d);
    checks++; if (d !== DW'(128 + reads)) begin errors++; $display("FAIL stall_stat2: got %0d exp %0d", d, 128 + reads); end
    bus_read(20'h00002, d);
    checks++; if (d !== 32'd64) begin errors++; $display("FAIL stall_stat1: got %0d exp 64", d); end
    dump_mem(63);
    for (int k = 0; k <= 63; k++) exp_q.push_back(model_mem[k]);
    for (int k = 0; k <= 63; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL stall_mem[%0d]: got %h exp %h", k, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d, e, a;
    logic [7:0] inc;
    int cyc, n, max_cnt, exp_cyc;
    for (int it = 0; it < 3; it++) begin
      max_cnt = $urandom_range(0, 40);
      inc = 8'($urandom_range(0, 255));
      bus_write(20'h00000, {8'h00, inc, 8'(max_cnt), 8'h01}, 4'hF);
      ref_run(max_cnt, inc, DEPTH, n);
      exp_cyc = (n == 0) ? 1 : 2 * n;
      wait_done(0, cyc);
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL b2b_done_time[%0d]: got %0d exp %0d", it, cyc, exp_cyc); end
      bus_read(20'h00002, d);
      checks++; if (d !== DW'(n)) begin errors++; $display("FAIL b2b_stat1[%0d]: got %0d exp %0d", it, d, n); end
    end
    dump_mem(47);
    for (int k = 0; k <= 47; k++) exp_q.push_back(model_mem[k]);
    for (int k = 0; k <= 47; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL b2b_mem[%0d]: got %h exp %h", k, a, e); end
    end
  endtask

  task automatic test_busy_start();
    logic [DW-1:0] d, e, a;
    int cyc, n;
    bus_write(20'h00000, 32'h0001_2001, 4'hF);
    ref_run(32, 8'd1, DEPTH, n);
    bus_read(20'h00001, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL busy_stat0: got %h exp 2", d); end
    bus_write(20'h00000, 32'h0005_0801, 4'hF);
    bus_read(20'h00000, d);
    checks++; if (d !== 32'h0005_0800) begin errors++; $display("FAIL busy_ctrl: got %h exp 00050800", d); end
    wait_done(3, cyc);
    checks++; if (cyc !== 64) begin errors++; $display("FAIL busy_done_time: got %0d exp 64", cyc); end
    bus_read(20'h00002, d);
    checks++; if (d !== 32'd32) begin errors++; $display("FAIL busy_stat1: got %0d exp 32", d); end
    dump_mem(39);
    for (int k = 0; k <= 39; k++) exp_q.push_back(model_mem[k]);
    for (int k = 0; k <= 39; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL busy_mem[%0d]: got %h exp %h", k, a, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d, e, a;
    int k_done, n;
    k_done = $urandom_range(1, 20);
    bus_write(20'h00000, 32'h0003_4001, 4'hF);
    ref_run(64, 8'd3, k_done, n);
    repeat (2 * k_done) idle_cycle();
    rst_n_s = 1'b0;
    #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b exp 0", done_o); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d exp 0", dbg_state); end
    @(negedge clk_s);
    rst_n_s = 1'b1;
    bus_read(20'h00000, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL rstmid_ctrl: got %h exp 0", d); end
    bus_read(20'h00002, d);
    checks++; if (d !== '0) begin errors++; $display("FAIL rstmid_stat1: got %h exp 0", d); end
    dump_mem(63);
    for (int k = 0; k <= 63; k++) exp_q.push_back(model_mem[k]);
    for (int k = 0; k <= 63; k++) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL rstmid_mem[%0d]: got %h exp %h", k, a, e); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
    bus.mem_be_i = '0; bus.mem_wdata_i = '0;
    rst_n_s = 1'b0;
    repeat (3) @(posedge clk_s);
    @(negedge clk_s);
    rst_n_s = 1'b1;
    #1;
    test_reset();
    init_mem();
    test_map();
    test_increment();
    test_zero_cnt();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
